// File: rtl/qspis_pkg.sv
// ---------------------------------------------------------------------------
// qspis_pkg
// Shared definitions for the QSPI-slave sequencer:
//   - command opcodes recognised in the command phase
//   - protocol FSM state type (also exported for debug observation)
//   - pad-ring bundles: pad_to_qspis_t (inputs) and qspis_to_pad_t (outputs)
// ---------------------------------------------------------------------------
package qspis_pkg;

  localparam logic [7:0] QSPIS_CMD_WRITE  = 8'h02;
  localparam logic [7:0] QSPIS_CMD_READ   = 8'h0B;
  localparam logic [7:0] QSPIS_CMD_QWRITE = 8'h38;
  localparam logic [7:0] QSPIS_CMD_QREAD  = 8'hEB;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_WDATA  = 3'd4,
    ST_RDATA  = 3'd5,
    ST_IGNORE = 3'd6
  } qspis_state_e;

  // Raw pad inputs: data lines, all four chip selects and the serial clock.
  typedef struct packed {
    logic [3:0] sd;
    logic [3:0] csn;
    logic       sck;
  } pad_to_qspis_t;

  // Pad outputs and their output enables.
  typedef struct packed {
    logic [3:0] sd_o;
    logic [3:0] sd_oe;
  } qspis_to_pad_t;

endpackage

// File: rtl/qspis_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// qspis_seq_ctrl_if
// Backend-side bundle of the QSPI-slave sequencer.
//   master modport : the sequencer (drives request/write-data/status,
//                    receives read data)
//   slave modport  : the backend
// Handshake rules:
//   req_valid_o   - one-cycle pulse; req_write_o/req_quad_o/req_addr_o are
//                   valid with it and held until the next request.
//   wdata_valid_o - one-cycle pulse per byte, no backpressure.
//   rdata_ready_o - one-cycle strobe; the byte on rdata_i is consumed when
//                   rdata_valid_i is high in that same cycle, otherwise the
//                   sequencer substitutes 0xFF and raises underrun_o.
// state_o exposes the protocol FSM state for observation.
// ---------------------------------------------------------------------------
interface qspis_seq_ctrl_if #(
  parameter int ADDR_BYTES = 3
) ();
  import qspis_pkg::*;

  logic                    req_valid_o;
  logic                    req_write_o;
  logic                    req_quad_o;
  logic [8*ADDR_BYTES-1:0] req_addr_o;
  logic                    wdata_valid_o;
  logic [7:0]              wdata_o;
  logic                    rdata_valid_i;
  logic [7:0]              rdata_i;
  logic                    rdata_ready_o;
  logic                    busy_o;
  logic                    bad_cmd_o;
  logic                    underrun_o;
  qspis_state_e            state_o;

  modport master (
    output req_valid_o, req_write_o, req_quad_o, req_addr_o,
    output wdata_valid_o, wdata_o,
    input  rdata_valid_i, rdata_i,
    output rdata_ready_o,
    output busy_o, bad_cmd_o, underrun_o, state_o
  );

  modport slave (
    input  req_valid_o, req_write_o, req_quad_o, req_addr_o,
    input  wdata_valid_o, wdata_o,
    output rdata_valid_i, rdata_i,
    input  rdata_ready_o,
    input  busy_o, bad_cmd_o, underrun_o, state_o
  );

endinterface

// File: rtl/qspis_sync_edge.sv
// ---------------------------------------------------------------------------
// qspis_sync_edge
// Two-flop synchroniser plus a third flop for edge detection.
// A pad edge shows up as a one-cycle rise/fall strobe on the third clk_i
// edge after it.
//   clk_i, rst_ni : system clock, async active-low reset
//   d_i           : asynchronous input
//   q_o           : synchronised level
//   rise_o/fall_o : one-cycle edge strobes
// RST_VAL sets the idle level the chain resets to (1 for chip selects, so
// reset does not look like a selection).
// ---------------------------------------------------------------------------
module qspis_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign q_o    = s2_q;
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/qspis_seq_ctrl.sv
// ---------------------------------------------------------------------------
// qspis_seq_ctrl
// Oversampling QSPI-slave protocol sequencer (SPI mode 0) in the clk_i domain.
// Decodes command / address / dummy / data phases and talks to the backend.
//   clk_i   : system clock, at least 6x sck
//   rst_ni  : async active-low reset
//   pad_i   : sd0..3 inputs, csn0..3, sck
//   pad_o   : sd0..3 outputs and output enables
//   bus     : backend bundle (request, write data, read data, status, state)
// Inputs are sampled on the synchronised sck rise, outputs change on the
// synchronised sck fall. Synchronised csn high forces IDLE from any state.
// ---------------------------------------------------------------------------
module qspis_seq_ctrl
  import qspis_pkg::*;
#(
  parameter int ADDR_BYTES   = 3,
  parameter int DUMMY_CYCLES = 8,
  parameter int CS_IDX       = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  pad_to_qspis_t     pad_i,
  output qspis_to_pad_t     pad_o,
  qspis_seq_ctrl_if.master  bus
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam logic [5:0] ADDR_LAST_S = 6'(8 * ADDR_BYTES - 1);
  localparam logic [5:0] ADDR_LAST_Q = 6'(2 * ADDR_BYTES - 1);
  localparam logic [5:0] DUMMY_N     = 6'(DUMMY_CYCLES);

  // Synchronisers
  logic sck_s, sck_rise, sck_fall;
  logic csn_s, csn_fall, csn_rise_unused;
  logic [3:0] sd_s1_q, sd_s_q;

  qspis_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pad_i.sck),
    .q_o    (sck_s),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  qspis_sync_edge #(.RST_VAL(1'b1)) u_csn_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pad_i.csn[CS_IDX]),
    .q_o    (csn_s),
    .rise_o (csn_rise_unused),
    .fall_o (csn_fall)
  );

  // Data lines share the sck chain's latency, so the value seen with the
  // rise strobe is the one the master set up before its rising edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sd_s1_q <= 4'h0;
      sd_s_q  <= 4'h0;
    end else begin
      sd_s1_q <= pad_i.sd;
      sd_s_q  <= sd_s1_q;
    end
  end

  logic unused_sig;
  assign unused_sig = ^{pad_i.csn, sck_s, csn_rise_unused};

  // Protocol state
  qspis_state_e  state_q;
  logic [5:0]    cnt_q;
  logic [7:0]    rx_q;
  logic [7:0]    tx_q;
  logic [AW-1:0] sh_q;
  logic          write_q, quad_q, oe_q;
  logic          req_valid_q, wdata_valid_q, rdata_ready_q, bad_cmd_q, underrun_q;
  logic [AW-1:0] req_addr_q;
  logic [7:0]    wdata_q;

  logic [7:0]    cmd_next;
  logic [7:0]    rx_next;
  logic [AW-1:0] addr_next;
  logic [5:0]    addr_last;
  logic [5:0]    data_last;

  assign cmd_next  = {rx_q[6:0], sd_s_q[0]};
  assign rx_next   = quad_q ? {rx_q[3:0], sd_s_q} : {rx_q[6:0], sd_s_q[0]};
  assign addr_next = quad_q ? {sh_q[AW-5:0], sd_s_q} : {sh_q[AW-2:0], sd_s_q[0]};
  assign addr_last = quad_q ? ADDR_LAST_Q : ADDR_LAST_S;
  // Bits (single) or nibbles (quad) per byte, minus one.
  assign data_last = quad_q ? 6'd1 : 6'd7;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 6'd0;
      rx_q          <= 8'h00;
      tx_q          <= 8'h00;
      sh_q          <= '0;
      write_q       <= 1'b0;
      quad_q        <= 1'b0;
      oe_q          <= 1'b0;
      req_valid_q   <= 1'b0;
      wdata_valid_q <= 1'b0;
      rdata_ready_q <= 1'b0;
      bad_cmd_q     <= 1'b0;
      underrun_q    <= 1'b0;
      req_addr_q    <= '0;
      wdata_q       <= 8'h00;
    end else begin
      req_valid_q   <= 1'b0;
      wdata_valid_q <= 1'b0;
      rdata_ready_q <= 1'b0;
      bad_cmd_q     <= 1'b0;
      if (csn_s) begin
        // Deselected: abandon whatever phase was in progress.
        state_q <= ST_IDLE;
        oe_q    <= 1'b0;
        cnt_q   <= 6'd0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (csn_fall) begin
              state_q    <= ST_CMD;
              cnt_q      <= 6'd0;
              underrun_q <= 1'b0;
            end
          end
          ST_CMD: begin
            if (sck_rise) begin
              rx_q  <= cmd_next;
              cnt_q <= cnt_q + 6'd1;
              if (cnt_q == 6'd7) begin
                cnt_q <= 6'd0;
                unique case (cmd_next)
                  QSPIS_CMD_WRITE:  begin write_q <= 1'b1; quad_q <= 1'b0; state_q <= ST_ADDR; end
                  QSPIS_CMD_READ:   begin write_q <= 1'b0; quad_q <= 1'b0; state_q <= ST_ADDR; end
                  QSPIS_CMD_QWRITE: begin write_q <= 1'b1; quad_q <= 1'b1; state_q <= ST_ADDR; end
                  QSPIS_CMD_QREAD:  begin write_q <= 1'b0; quad_q <= 1'b1; state_q <= ST_ADDR; end
                  default: begin
                    bad_cmd_q <= 1'b1;
                    state_q   <= ST_IGNORE;
                  end
                endcase
              end
            end
          end
          ST_ADDR: begin
            if (sck_rise) begin
              sh_q <= addr_next;
              if (cnt_q == addr_last) begin
                cnt_q       <= 6'd0;
                req_addr_q  <= addr_next;
                req_valid_q <= 1'b1;
                state_q     <= write_q ? ST_WDATA : ST_DUMMY;
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end
          end
          ST_DUMMY: begin
            // Count rises, then the next fall launches the first read byte.
            if (sck_rise && cnt_q != DUMMY_N) begin
              cnt_q <= cnt_q + 6'd1;
            end else if (sck_fall && cnt_q == DUMMY_N) begin
              cnt_q         <= 6'd0;
              rdata_ready_q <= 1'b1;
              tx_q          <= bus.rdata_valid_i ? bus.rdata_i : 8'hFF;
              if (!bus.rdata_valid_i) underrun_q <= 1'b1;
              oe_q          <= 1'b1;
              state_q       <= ST_RDATA;
            end
          end
          ST_WDATA: begin
            if (sck_rise) begin
              rx_q <= rx_next;
              if (cnt_q == data_last) begin
                cnt_q         <= 6'd0;
                wdata_q       <= rx_next;
                wdata_valid_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end
          end
          ST_RDATA: begin
            if (sck_fall) begin
              if (cnt_q == data_last) begin
                cnt_q         <= 6'd0;
                rdata_ready_q <= 1'b1;
                tx_q          <= bus.rdata_valid_i ? bus.rdata_i : 8'hFF;
                if (!bus.rdata_valid_i) underrun_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 6'd1;
                tx_q  <= quad_q ? {tx_q[3:0], 4'h0} : {tx_q[6:0], 1'b0};
              end
            end
          end
          ST_IGNORE: begin
            // Wait for deselect.
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Single mode drives only sd1 (MISO); quad drives all four lines.
  assign pad_o.sd_oe = oe_q ? (quad_q ? 4'hF : 4'b0010) : 4'h0;
  assign pad_o.sd_o  = oe_q ? (quad_q ? tx_q[7:4] : {2'b00, tx_q[7], 1'b0}) : 4'h0;

  assign bus.req_valid_o   = req_valid_q;
  assign bus.req_write_o   = write_q;
  assign bus.req_quad_o    = quad_q;
  assign bus.req_addr_o    = req_addr_q;
  assign bus.wdata_valid_o = wdata_valid_q;
  assign bus.wdata_o       = wdata_q;
  assign bus.rdata_ready_o = rdata_ready_q;
  assign bus.busy_o        = ~csn_s;
  assign bus.bad_cmd_o     = bad_cmd_q;
  assign bus.underrun_o    = underrun_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_qspis_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_qspis_seq_ctrl
// Bench for the QSPI-slave sequencer: a master model drives whole frames,
// a monitor records backend pulses, a backend model feeds read bytes.
// ---------------------------------------------------------------------------
module tb_qspis_seq_ctrl;
  import qspis_pkg::*;

  localparam int H = 5;  // clk_i cycles per sck half period

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pad_to_qspis_t pad;
  qspis_to_pad_t pad_o;

  qspis_seq_ctrl_if #(.ADDR_BYTES(3)) bus ();

  qspis_seq_ctrl #(
    .ADDR_BYTES   (3),
    .DUMMY_CYCLES (8),
    .CS_IDX       (0)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .pad_i  (pad),
    .pad_o  (pad_o),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        rvalid;
    logic        exp_req;
    logic        exp_write;
    logic        exp_quad;
    logic        exp_bad;
    logic        exp_underrun;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Monitor state
  int         n_req, n_wd, n_ready, n_badcmd;
  logic       cap_write, cap_quad;
  logic [23:0] cap_addr;
  logic [7:0] got_w[$];
  logic [7:0] be_q[$];
  logic       be_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor plus backend: pops a byte when it is consumed.
  always @(negedge clk) begin
    if (bus.req_valid_o) begin
      n_req++;
      cap_write = bus.req_write_o;
      cap_quad  = bus.req_quad_o;
      cap_addr  = bus.req_addr_o;
    end
    if (bus.wdata_valid_o) got_w.push_back(bus.wdata_o);
    if (bus.bad_cmd_o) n_badcmd++;
    if (bus.rdata_ready_o) begin
      n_ready++;
      if (bus.rdata_valid_i && be_q.size() > 0) void'(be_q.pop_front());
    end
    bus.rdata_valid_i = be_valid && (be_q.size() > 0);
    bus.rdata_i       = (be_q.size() > 0) ? be_q[0] : 8'h00;
  end

  // Reference model: what a frame should produce, from the command rules.
  function automatic vec_t model(input logic [7:0] cmd, input logic [23:0] addr,
                                 input logic [7:0] d0, input logic [7:0] d1, input logic rvalid);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.d0 = d0; v.d1 = d1; v.rvalid = rvalid;
    v.exp_req = 1'b1; v.exp_bad = 1'b0; v.exp_write = 1'b0; v.exp_quad = 1'b0;
    if (cmd == 8'h02)      begin v.exp_write = 1'b1; end
    else if (cmd == 8'h0B) begin end
    else if (cmd == 8'h38) begin v.exp_write = 1'b1; v.exp_quad = 1'b1; end
    else if (cmd == 8'hEB) begin v.exp_quad = 1'b1; end
    else begin v.exp_req = 1'b0; v.exp_bad = 1'b1; end
    v.exp_underrun = v.exp_req && !v.exp_write && !rvalid;
    return v;
  endfunction

  // Master driver: one sck period (fall, setup, rise) with input sampling.
  task automatic sbit(input logic [3:0] v, output logic [3:0] sd_seen, output logic [3:0] oe_seen);
    pad.sck = 1'b0;
    pad.sd  = v;
    repeat (H) @(negedge clk);
    sd_seen = pad_o.sd_o;
    oe_seen = pad_o.sd_oe;
    pad.sck = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic end_frame();
    // Deselect while sck is still high so no trailing fall is seen selected.
    pad.csn[0] = 1'b1;
    repeat (6) @(negedge clk);
    pad.sck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_mon();
    n_req = 0; n_wd = 0; n_ready = 0; n_badcmd = 0;
    got_w.delete();
  endtask

  task automatic run_frame(input vec_t v);
    logic [3:0] s, o;
    logic [7:0] rb, eb, d;
    logic       oe_err, rd_oe_err;
    logic [3:0] rd_oe;
    clear_mon();
    be_q.delete();
    be_valid = v.rvalid;
    if (v.exp_req && !v.exp_write) begin
      be_q.push_back(v.d0);
      be_q.push_back(v.d1);
    end
    oe_err = 1'b0; rd_oe_err = 1'b0;
    rd_oe = v.exp_quad ? 4'hF : 4'b0010;
    pad.csn[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("underrun_clr", {31'd0, bus.underrun_o}, 32'd0);
    check("busy_hi", {31'd0, bus.busy_o}, 32'd1);
    for (int i = 7; i >= 0; i--) begin
      sbit({3'b000, v.cmd[i]}, s, o);
      if (o != 4'h0) oe_err = 1'b1;
    end
    if (v.exp_bad) begin
      for (int i = 0; i < 16; i++) begin
        sbit(4'($urandom_range(0, 15)), s, o);
        if (o != 4'h0) oe_err = 1'b1;
      end
    end else begin
      if (v.exp_quad) begin
        for (int n = 5; n >= 0; n--) begin
          sbit(v.addr[n*4 +: 4], s, o);
          if (o != 4'h0) oe_err = 1'b1;
        end
      end else begin
        for (int i = 23; i >= 0; i--) begin
          sbit({3'b000, v.addr[i]}, s, o);
          if (o != 4'h0) oe_err = 1'b1;
        end
      end
      if (v.exp_write) begin
        for (int k = 0; k < 2; k++) begin
          d = (k == 0) ? v.d0 : v.d1;
          if (v.exp_quad) begin
            sbit(d[7:4], s, o); if (o != 4'h0) oe_err = 1'b1;
            sbit(d[3:0], s, o); if (o != 4'h0) oe_err = 1'b1;
          end else begin
            for (int i = 7; i >= 0; i--) begin
              sbit({3'b000, d[i]}, s, o);
              if (o != 4'h0) oe_err = 1'b1;
            end
          end
        end
      end else begin
        for (int i = 0; i < 8; i++) begin
          sbit(4'($urandom_range(0, 15)), s, o);
          if (o != 4'h0) oe_err = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
          d  = (k == 0) ? v.d0 : v.d1;
          eb = v.rvalid ? d : 8'hFF;
          rb = 8'h00;
          if (v.exp_quad) begin
            sbit(4'h0, s, o); rb[7:4] = s; if (o != rd_oe) rd_oe_err = 1'b1;
            sbit(4'h0, s, o); rb[3:0] = s; if (o != rd_oe) rd_oe_err = 1'b1;
          end else begin
            for (int i = 7; i >= 0; i--) begin
              sbit(4'h0, s, o);
              rb[i] = s[1];
              if (o != rd_oe) rd_oe_err = 1'b1;
            end
          end
          check(k == 0 ? "rd_byte0" : "rd_byte1", {24'd0, rb}, {24'd0, eb});
        end
        check("rd_oe", {31'd0, rd_oe_err}, 32'd0);
      end
    end
    end_frame();
    check("oe_idle_phases", {31'd0, oe_err}, 32'd0);
    check("req_count", n_req, {31'd0, v.exp_req});
    if (v.exp_req) begin
      check("req_write", {31'd0, cap_write}, {31'd0, v.exp_write});
      check("req_quad", {31'd0, cap_quad}, {31'd0, v.exp_quad});
      check("req_addr", {8'd0, cap_addr}, {8'd0, v.addr});
    end
    check("bad_cmd_count", n_badcmd, {31'd0, v.exp_bad});
    check("wdata_count", got_w.size(), (v.exp_req && v.exp_write) ? 32'd2 : 32'd0);
    if (got_w.size() == 2) begin
      check("wdata0", {24'd0, got_w[0]}, {24'd0, v.d0});
      check("wdata1", {24'd0, got_w[1]}, {24'd0, v.d1});
    end
    check("ready_count", n_ready, (v.exp_req && !v.exp_write) ? 32'd2 : 32'd0);
    check("underrun_end", {31'd0, bus.underrun_o}, {31'd0, v.exp_underrun});
    check("pad_o_after", {24'd0, pad_o}, 32'd0);
    check("state_after", {29'd0, bus.state_o}, {29'd0, ST_IDLE});
    check("busy_after", {31'd0, bus.busy_o}, 32'd0);
  endtask

  vec_t tbl[6];
  logic [7:0] legal[4];

  initial begin
    logic [3:0] s, o;
    vec_t v;
    logic [7:0] c;
    int idx;

    pad = '0;
    pad.csn = 4'hF;
    clear_mon();

    tbl[0] = '{8'h02, 24'h123456, 8'hA5, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h0B, 24'h000010, 8'h81, 8'h7E, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{8'hEB, 24'hABCDEF, 8'hF0, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h0B, 24'h00FF00, 8'h12, 8'h34, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h9F, 24'h000000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'h38, 24'h5A5A5A, 8'hC3, 8'hE1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    legal[0] = 8'h02; legal[1] = 8'h0B; legal[2] = 8'h38; legal[3] = 8'hEB;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_pad_o", {24'd0, pad_o}, 32'd0);
    check("rst_state", {29'd0, bus.state_o}, {29'd0, ST_IDLE});
    check("rst_pulses", {28'd0, bus.req_valid_o, bus.wdata_valid_o, bus.rdata_ready_o, bus.bad_cmd_o}, 32'd0);
    check("rst_status", {30'd0, bus.busy_o, bus.underrun_o}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Directed table
    for (int t = 0; t < 6; t++) run_frame(tbl[t]);

    // Abort mid second write byte
    clear_mon();
    pad.csn[0] = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 7; i >= 0; i--) sbit({3'b000, legal[0][i]}, s, o);
    for (int i = 23; i >= 0; i--) sbit({3'b000, 1'(i % 3 == 0)}, s, o);
    for (int i = 7; i >= 0; i--) sbit({3'b000, tbl[0].d0[i]}, s, o);
    for (int i = 7; i >= 4; i--) sbit({3'b000, tbl[0].d1[i]}, s, o);
    pad.csn[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle_3clk", {29'd0, bus.state_o}, {29'd0, ST_IDLE});
    repeat (4) @(negedge clk);
    pad.sck = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_wdata_count", got_w.size(), 32'd1);
    if (got_w.size() > 0) check("abort_wdata0", {24'd0, got_w[0]}, {24'd0, tbl[0].d0});

    // Reset in the middle of an address phase
    clear_mon();
    pad.csn[0] = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 7; i >= 0; i--) sbit({3'b000, legal[1][i]}, s, o);
    for (int i = 0; i < 4; i++) sbit(4'h1, s, o);
    rst_n = 1'b0;
    #1;
    check("midrst_state", {29'd0, bus.state_o}, {29'd0, ST_IDLE});
    check("midrst_pad_o", {24'd0, pad_o}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
    pad.csn[0] = 1'b1;
    pad.sck = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_pulses", n_req + n_badcmd + n_ready + got_w.size(), 32'd0);

    // Follow-on frame after the abort/reset decodes normally
    run_frame(tbl[0]);

    // Randomized frames against the model
    for (int r = 0; r < 10; r++) begin
      idx = $urandom_range(0, 4);
      if (idx < 4) c = legal[idx];
      else begin
        c = 8'($urandom_range(0, 255));
        while (c == 8'h02 || c == 8'h0B || c == 8'h38 || c == 8'hEB) c = 8'($urandom_range(0, 255));
      end
      v = model(c, 24'($urandom), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)));
      run_frame(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/qspis_seq_ctrl.md
Name: qspis_seq_ctrl

Overview:
- Oversampling QSPI-slave protocol sequencer in the system clock domain.
- Synchronises the pad bundle (pad_to_qspis_t) and decodes command, address, dummy and data phases with an FSM.
- Drives the pad output/enable bundle (qspis_to_pad_t) and hands address and data bytes to a backend through pulse and valid/ready interfaces.
- Sits between the pad ring and the AXI-side backend of the SPI slave.

Parameters:
- ADDR_BYTES, 3, address length in bytes; legal range 1..4.
- DUMMY_CYCLES, 8, sck cycles between the address phase and read data; legal range 1..15.
- CS_IDX, 0, which csnN_i line (0..3) selects this slave.

Ports:
- clk_i  in  1  system clock; must be at least 6x the sck frequency.
- rst_ni  in  1  reset, asynchronous, active-low.
- pad_i  in  pad_to_qspis_t  sd0..3 inputs, csn0..3, sck.
- pad_o  out  qspis_to_pad_t  sd0..3 outputs and output enables.
- req_valid_o  out  1  one-cycle pulse when the address phase completes.
- req_write_o  out  1  write command; valid with req_valid_o.
- req_quad_o  out  1  quad command; valid with req_valid_o.
- req_addr_o  out  8*ADDR_BYTES  address, MSB first; valid with req_valid_o, held until the next request.
- wdata_valid_o  out  1  one-cycle pulse per received write byte.
- wdata_o  out  8  received write byte.
- rdata_valid_i  in  1  backend has a read byte.
- rdata_i  in  8  read byte.
- rdata_ready_o  out  1  one-cycle strobe; the byte is consumed if rdata_valid_i is high in the same cycle.
- busy_o  out  1  synchronised csn active.
- bad_cmd_o  out  1  one-cycle pulse on an unknown command.
- underrun_o  out  1  sticky; cleared on the next csn assertion.

Behaviour:
- Reset: all outputs 0, pad_o all 0 (every oe low), state IDLE.
- Synchronisers: 2-flop sync on sck, the selected csn and sd0..3. A third sck flop provides edge detection.
  - rise/fall strobe occurs 3 clk_i edges after the pad edge.
- Protocol: SPI mode 0.
  - Inputs are sampled on the sck rise strobe.
  - Outputs are updated on the sck fall strobe.
- States: IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, IGNORE.
- Synchronised csn high in any state:
  - next cycle: state IDLE, all oe low, counters cleared;
  - no further pulses are generated;
  - a partially received byte is discarded.
- IDLE -> CMD on csn falling edge (synchronised); clears underrun_o.
- CMD: 8 rise strobes shift sd0 in, MSB first. Decode on the 8th:
  - 0x02: single write.
  - 0x0B: single read.
  - 0x38: quad write.
  - 0xEB: quad read.
  - Any other value: bad_cmd_o pulse, go to IGNORE.
- ADDR: shifts sd0 (1 bit/rise) or sd3..sd0 (4 bits/rise, sd3 = MSB).
  - Lasts 8*ADDR_BYTES or 2*ADDR_BYTES rises.
  - On the last rise: req_valid_o pulse, then go to WDATA (write) or DUMMY (read).
- DUMMY: counts DUMMY_CYCLES rise strobes.
  - On the fall strobe after the last counted rise, load the first read byte, enable outputs, go to RDATA.
- WDATA: after 8 (single) or 2 (quad) rises:
  - wdata_o updates, wdata_valid_o pulses in the same cycle;
  - no backpressure.
- RDATA: shift register.
  - Single mode: sd1_o = bit 7, sd1_oe = 1, all other oe = 0.
  - Quad mode: sd3..sd0 = upper nibble, all four oe = 1.
  - Shift on each fall strobe.
  - On each byte boundary fall strobe: rdata_ready_o pulses and rdata_i is loaded.
  - If rdata_valid_i is low on that strobe: load 0xFF and set underrun_o.
- Bit and nibble counters wrap per byte; byte streaming is unbounded until csn deasserts.
- sck edges while csn is high are ignored.
- Reset assertion mid-transfer: immediate return to reset values; no pulses.

Decomposition:
- Shared package (qspis_pkg) gets:
  - command opcode constants (QSPIS_CMD_WRITE = 8'h02, QSPIS_CMD_READ = 8'h0B, QSPIS_CMD_QWRITE = 8'h38, QSPIS_CMD_QREAD = 8'hEB);
  - the state enum type qspis_state_e.
- One sub-module: qspis_sync_edge — a 2-flop synchroniser with rise/fall strobes, instantiated for sck and csn.
- sd0..3 use plain 2-flop syncs.

Test Plan:
- Single write, cmd 0x02, addr 0x123456, bytes 0xA5 0x3C -> one req_valid_o (write=1, quad=0, addr=0x123456); two wdata_valid_o pulses carrying 0xA5 then 0x3C.
- Single read 0x0B, addr 0x000010, 8 dummy cycles, backend supplies 0x81 then 0x7E -> sd1 carries 10000001 01111110; sd1_oe is high only in RDATA; rdata_ready_o pulses twice.
- Quad read 0xEB, addr 0xABCDEF via nibbles, backend 0xF0 -> sd3..0 = 0xF then 0x0; all oe = 1; req_quad_o = 1.
- Read with rdata_valid_i held 0 -> data 0xFF on the pins; underrun_o = 1 until the next csn fall.
- Command 0x9F -> bad_cmd_o single pulse; no req/wdata pulses; oe stays 0 for the rest of the frame.
- csn raised after 4 bits of the 2nd write byte -> exactly one wdata_valid_o pulse; IDLE within 3 clk_i; a follow-on frame decodes normally.
